// File: rtl/sd_access_sched_if.sv
// Bundle of request, status and core-control signals between the SD access
// scheduler (slave side) and the requesters plus SPI core (master side).
interface sd_access_sched_if;
    logic        rd_req;
    logic [31:0] rd_sec;
    logic        wr_req;
    logic [31:0] wr_sec;
    logic        rd_done;
    logic        wr_done;
    logic        ready;
    logic        err;
    logic        sd_init;
    logic        sd_ren;
    logic        sd_wen;
    logic [31:0] sec;
    logic        fifo_busy;
    logic        init_ok;
    logic        rd_ok;
    logic        wr_ok;

    modport master (
        output rd_req, rd_sec, wr_req, wr_sec, init_ok, rd_ok, wr_ok,
        input  rd_done, wr_done, ready, err, sd_init, sd_ren, sd_wen, sec, fifo_busy
    );

    modport slave (
        input  rd_req, rd_sec, wr_req, wr_sec, init_ok, rd_ok, wr_ok,
        output rd_done, wr_done, ready, err, sd_init, sd_ren, sd_wen, sec, fifo_busy
    );
endinterface

// File: rtl/sd_access_sched.sv
// Sequencer/arbiter in front of the SD-card SPI core: power-up init, round-robin
// read/write grants, fifo_busy acknowledge and a per-transaction watchdog.
module sd_access_sched #(
    parameter int unsigned POWERUP_CYCLES = 4096,
    parameter int unsigned ACK_CYCLES     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
    input logic              clk,
    input logic              rst_n,
    sd_access_sched_if.slave bus
);

    typedef enum logic [2:0] {
        PWRUP, INIT, INIT_ACK, IDLE, RD, WR, REL, ERR
    } state_t;

    localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] ACK_LAST = 32'(ACK_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] sec_q, sec_d;
    logic [1:0]  init_sync_q, init_sync_d;
    logic [1:0]  rd_sync_q, rd_sync_d;
    logic [1:0]  wr_sync_q, wr_sync_d;
    logic        last_rd_q, last_rd_d;
    logic        sd_init_q, sd_init_d;
    logic        sd_ren_q, sd_ren_d;
    logic        sd_wen_q, sd_wen_d;
    logic        fifo_busy_q, fifo_busy_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        rd_done_q, rd_done_d;
    logic        wr_done_q, wr_done_d;

    logic s_init, s_rd, s_wr;
    logic wd_expired;
    logic grant_rd, grant_wr;
    logic active_ok;

    assign s_init     = init_sync_q[1];
    assign s_rd       = rd_sync_q[1];
    assign s_wr       = wr_sync_q[1];
    assign wd_expired = (cnt_q == TMO_LAST);

    // last_rd_q=0 means the previous grant was a write, so a tie goes to read.
    assign grant_rd  = bus.rd_req && (!bus.wr_req || !last_rd_q);
    assign grant_wr  = bus.wr_req && !grant_rd;
    assign active_ok = last_rd_q ? s_rd : s_wr;

    always_comb begin
        init_sync_d = {init_sync_q[0], bus.init_ok};
        rd_sync_d   = {rd_sync_q[0], bus.rd_ok};
        wr_sync_d   = {wr_sync_q[0], bus.wr_ok};

        state_d     = state_q;
        cnt_d       = cnt_q;
        sec_d       = sec_q;
        last_rd_d   = last_rd_q;
        sd_init_d   = sd_init_q;
        sd_ren_d    = sd_ren_q;
        sd_wen_d    = sd_wen_q;
        fifo_busy_d = fifo_busy_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;

        case (state_q)
            PWRUP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == PWR_LAST) begin
                    state_d   = INIT;
                    sd_init_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            INIT: begin
                cnt_d = cnt_q + 32'd1;
                if (s_init) begin
                    state_d     = INIT_ACK;
                    sd_init_d   = 1'b0;
                    fifo_busy_d = 1'b1;
                    cnt_d       = '0;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            INIT_ACK: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == ACK_LAST) begin
                    state_d     = IDLE;
                    fifo_busy_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (grant_rd) begin
                    state_d   = RD;
                    sec_d     = bus.rd_sec;
                    sd_ren_d  = 1'b1;
                    last_rd_d = 1'b1;
                    ready_d   = 1'b0;
                    cnt_d     = '0;
                end else if (grant_wr) begin
                    state_d   = WR;
                    sec_d     = bus.wr_sec;
                    sd_wen_d  = 1'b1;
                    last_rd_d = 1'b0;
                    ready_d   = 1'b0;
                    cnt_d     = '0;
                end
            end
            RD: begin
                cnt_d = cnt_q + 32'd1;
                if (s_rd) begin
                    state_d     = REL;
                    sd_ren_d    = 1'b0;
                    fifo_busy_d = 1'b1;
                    cnt_d       = '0;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            WR: begin
                cnt_d = cnt_q + 32'd1;
                if (s_wr) begin
                    state_d     = REL;
                    sd_wen_d    = 1'b0;
                    fifo_busy_d = 1'b1;
                    cnt_d       = '0;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            REL: begin
                cnt_d = cnt_q + 32'd1;
                if (!active_ok) begin
                    state_d     = IDLE;
                    fifo_busy_d = 1'b0;
                    rd_done_d   = last_rd_q;
                    wr_done_d   = !last_rd_q;
                    cnt_d       = '0;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase

        // Any path into ERR (or staying there) forces the core quiet and latches err.
        if (state_d == ERR) begin
            sd_init_d   = 1'b0;
            sd_ren_d    = 1'b0;
            sd_wen_d    = 1'b0;
            fifo_busy_d = 1'b0;
            ready_d     = 1'b0;
            rd_done_d   = 1'b0;
            wr_done_d   = 1'b0;
            err_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            sec_q       <= '0;
            init_sync_q <= '0;
            rd_sync_q   <= '0;
            wr_sync_q   <= '0;
            last_rd_q   <= 1'b0;
            sd_init_q   <= 1'b0;
            sd_ren_q    <= 1'b0;
            sd_wen_q    <= 1'b0;
            fifo_busy_q <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sec_q       <= sec_d;
            init_sync_q <= init_sync_d;
            rd_sync_q   <= rd_sync_d;
            wr_sync_q   <= wr_sync_d;
            last_rd_q   <= last_rd_d;
            sd_init_q   <= sd_init_d;
            sd_ren_q    <= sd_ren_d;
            sd_wen_q    <= sd_wen_d;
            fifo_busy_q <= fifo_busy_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign bus.sd_init   = sd_init_q;
    assign bus.sd_ren    = sd_ren_q;
    assign bus.sd_wen    = sd_wen_q;
    assign bus.sec       = sec_q;
    assign bus.fifo_busy = fifo_busy_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.wr_done   = wr_done_q;

endmodule
